// File: rtl/seg_pkg.sv
// seg_pkg: constants and types shared by the seven-segment scan driver and its decoder.
package seg_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } dig_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIG_OFF   = 4'b1111;

  // Active-low segments, bit order {g,f,e,d,c,b,a}, indexed by hex value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: registered hex-to-seven-segment decoder with a blank override.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       blank,
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
    end else if (blank) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= SEG_TABLE[hex];
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit multiplexed seven-segment scanner with tear-free frame updates.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  dig_sel,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned   CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  dig_idx_t      idx, idx_nxt;
  logic [15:0]   disp_data, disp_data_nxt, pend_data, pend_data_nxt;
  logic [3:0]    disp_dp, disp_dp_nxt, pend_dp, pend_dp_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic          frame_end, blank_nxt, lz_blank;
  logic [3:0]    nibble_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= DIG0;
      disp_data <= '0;
      disp_dp   <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_vld  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      pend_data <= pend_data_nxt;
      pend_dp   <= pend_dp_nxt;
      pend_vld  <= pend_vld_nxt;
    end
  end

  always_comb begin
    frame_end     = (cnt == CNT_LAST) && (idx == DIG3);
    cnt_nxt       = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt       = idx;
    disp_data_nxt = disp_data;
    disp_dp_nxt   = disp_dp;
    pend_data_nxt = pend_data;
    pend_dp_nxt   = pend_dp;
    pend_vld_nxt  = pend_vld;

    if (cnt == CNT_LAST) begin
      idx_nxt = dig_idx_t'(idx + 2'd1);
    end

    // A load on the boundary edge bypasses pending and lands in the display directly
    if (frame_end) begin
      if (load) begin
        disp_data_nxt = data_in;
        disp_dp_nxt   = dp_in;
      end else if (pend_vld) begin
        disp_data_nxt = pend_data;
        disp_dp_nxt   = pend_dp;
      end
      pend_vld_nxt = 1'b0;
    end else if (load) begin
      pend_data_nxt = data_in;
      pend_dp_nxt   = dp_in;
      pend_vld_nxt  = 1'b1;
    end

    blank_nxt  = (BLANK_CYC != 0) && (cnt_nxt <= BLANK_LAST);
    nibble_nxt = disp_data_nxt[{idx_nxt, 2'b00} +: 4];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Shifting out the lower digits leaves this digit and all higher ones
  assign lz_blank = (idx_nxt != DIG0) && ((disp_data_nxt >> {idx_nxt, 2'b00}) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  // Outputs are registered from next-state values so they stay aligned with the slot counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_sel    <= DIG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      dig_sel    <= blank_nxt ? DIG_OFF : ~(4'b0001 << idx_nxt);
      dp         <= blank_nxt | ~disp_dp_nxt[idx_nxt];
      frame_done <= frame_end;
    end
  end

  hex7seg_dec u_dec (
    .clk   (clk),
    .rst   (rst),
    .blank (blank_nxt | lz_blank),
    .hex   (nibble_nxt),
    .seg   (seg)
  );

endmodule
